// File: rtl/mux_n_pipe.sv
// mux_n_pipe: N-input, WIDTH-bit registered selector with a valid/ready
// handshake, a 2-entry (main + skid) buffer, synchronous flush and an
// out-of-range select flag.
//
// Ports:
//   clk      clock, all state updates on the rising edge
//   rst      synchronous reset, active-high
//   iC       flattened channels, channel k = iC[k*WIDTH +: WIDTH]
//   iSel     channel select, sampled with the beat
//   iValid   upstream beat present
//   oReady   block can accept a beat this cycle (depends on state only)
//   iFlush   discard all buffered beats
//   oZ       selected data of the head beat
//   oSelErr  head beat had iSel >= N (its data is forced to zero)
//   oValid   oZ/oSelErr hold a valid beat
//   iReady   downstream accepts the head beat
module mux_n_pipe #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*WIDTH-1:0] iC,
  input  logic [SEL_W-1:0]   iSel,
  input  logic               iValid,
  output logic               oReady,
  input  logic               iFlush,
  output logic [WIDTH-1:0]   oZ,
  output logic               oSelErr,
  output logic               oValid,
  input  logic               iReady
);

  // One extra bit so the bound still fits when N == 2**SEL_W.
  localparam logic [SEL_W:0] NUM_CH = (SEL_W + 1)'(N);

  logic [WIDTH-1:0] main_z;
  logic             main_err;
  logic             main_v;
  logic [WIDTH-1:0] skid_z;
  logic             skid_err;
  logic             skid_v;

  logic [WIDTH-1:0] sel_z;
  logic             sel_err;
  logic             accept;
  logic             consume;
  logic             main_free;

  always_comb begin
    sel_err = ({1'b0, iSel} >= NUM_CH);
    sel_z   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (iSel == SEL_W'(k)) begin
        sel_z = iC[k*WIDTH +: WIDTH];
      end
    end
    if (sel_err) begin
      sel_z = '0;
    end
  end

  assign oReady    = !rst && !skid_v;
  assign accept    = iValid && oReady;
  assign consume   = main_v && iReady;
  assign main_free = !main_v || consume;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_z   <= '0;
      main_err <= 1'b0;
      main_v   <= 1'b0;
      skid_z   <= '0;
      skid_err <= 1'b0;
      skid_v   <= 1'b0;
    end else if (iFlush) begin
      main_z   <= '0;
      main_err <= 1'b0;
      main_v   <= 1'b0;
      skid_v   <= 1'b0;
    end else if (main_free) begin
      // A full skid means oReady was low, so nothing can be accepted here.
      if (skid_v) begin
        main_z   <= skid_z;
        main_err <= skid_err;
        main_v   <= 1'b1;
        skid_v   <= 1'b0;
      end else if (accept) begin
        main_z   <= sel_z;
        main_err <= sel_err;
        main_v   <= 1'b1;
      end else begin
        main_v   <= 1'b0;
      end
    end else if (accept) begin
      // Head is stalled: park the new beat so oZ/oSelErr stay stable.
      skid_z   <= sel_z;
      skid_err <= sel_err;
      skid_v   <= 1'b1;
    end
  end

  assign oZ      = main_z;
  assign oSelErr = main_err;
  assign oValid  = main_v;

endmodule

// File: tb/tb_mux_n_pipe.sv
// tb_mux_n_pipe: scoreboard bench for mux_n_pipe. Two instances share all
// inputs: dut4 (N=4) and dut3 (N=3, so iSel=3 is out of range). The driver
// pushes expected beats into per-instance queues; a monitor on the falling
// edge compares the head beat against the queue front.
module tb_mux_n_pipe;

  typedef struct {
    logic [31:0] z;
    logic        err;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] ic4;
  logic [95:0]  ic3;
  logic [1:0]   iSel;
  logic         iValid;
  logic         iFlush;
  logic         iReady;

  logic         oReady4, oSelErr4, oValid4;
  logic [31:0]  oZ4;
  logic         oReady3, oSelErr3, oValid3;
  logic [31:0]  oZ3;

  int errors = 0;
  int checks = 0;

  beat_t q4[$];
  beat_t q3[$];

  logic [31:0] chan [4] = '{32'hAAAA0000, 32'hBBBB0001, 32'hCCCC0002, 32'hDDDD0003};

  always #5 clk = ~clk;

  mux_n_pipe #(.WIDTH(32), .N(4), .SEL_W(2)) dut4 (
    .clk(clk), .rst(rst), .iC(ic4), .iSel(iSel), .iValid(iValid),
    .oReady(oReady4), .iFlush(iFlush), .oZ(oZ4), .oSelErr(oSelErr4),
    .oValid(oValid4), .iReady(iReady)
  );

  mux_n_pipe #(.WIDTH(32), .N(3), .SEL_W(2)) dut3 (
    .clk(clk), .rst(rst), .iC(ic3), .iSel(iSel), .iValid(iValid),
    .oReady(oReady3), .iFlush(iFlush), .oZ(oZ3), .oSelErr(oSelErr3),
    .oValid(oValid3), .iReady(iReady)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int sel);
    beat_t b;
    b.z   = chan[sel];
    b.err = 1'b0;
    q4.push_back(b);
    if (sel >= 3) begin
      b.z   = 32'h0;
      b.err = 1'b1;
    end
    q3.push_back(b);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int sel, input logic rdy, input logic exp_rdy);
    iSel   = 2'(sel);
    iValid = 1'b1;
    iReady = rdy;
    @(negedge clk);
    chk("beat_oReady4", 32'(oReady4), 32'(exp_rdy));
    chk("beat_oReady3", 32'(oReady3), 32'(exp_rdy));
    if (exp_rdy) push(sel);
    next_cycle();
    iValid = 1'b0;
  endtask

  task automatic idle(input logic rdy, input logic exp_rdy);
    iValid = 1'b0;
    iReady = rdy;
    @(negedge clk);
    chk("idle_oReady4", 32'(oReady4), 32'(exp_rdy));
    next_cycle();
  endtask

  task automatic chk_empty_out(input string tag, input logic exp_rdy);
    chk({tag, "_oValid"}, 32'(oValid4), 32'd0);
    chk({tag, "_oZ"}, oZ4, 32'h0);
    chk({tag, "_oSelErr"}, 32'(oSelErr4), 32'd0);
    chk({tag, "_oReady"}, 32'(oReady4), 32'(exp_rdy));
    chk({tag, "_oValid3"}, 32'(oValid3), 32'd0);
    chk({tag, "_oSelErr3"}, 32'(oSelErr3), 32'd0);
  endtask

  // Monitor: compare the head beat every cycle it is valid (this also covers
  // stability while stalled); pop only when it is being consumed.
  always @(negedge clk) begin
    if (oValid4) begin
      if (q4.size() == 0) begin
        errors++; checks++;
        $display("FAIL dut4_unexpected_beat: got oZ=%h expected no beat", oZ4);
      end else begin
        chk("dut4_oZ", oZ4, q4[0].z);
        chk("dut4_oSelErr", 32'(oSelErr4), 32'(q4[0].err));
        if (iReady) void'(q4.pop_front());
      end
    end
    if (oValid3) begin
      if (q3.size() == 0) begin
        errors++; checks++;
        $display("FAIL dut3_unexpected_beat: got oZ=%h expected no beat", oZ3);
      end else begin
        chk("dut3_oZ", oZ3, q3[0].z);
        chk("dut3_oSelErr", 32'(oSelErr3), 32'(q3[0].err));
        if (iReady) void'(q3.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ic4    = {chan[3], chan[2], chan[1], chan[0]};
    ic3    = {chan[2], chan[1], chan[0]};
    rst    = 1'b1;
    iSel   = '0;
    iValid = 1'b0;
    iFlush = 1'b0;
    iReady = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk);
    chk_empty_out("reset", 1'b0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("release_oReady", 32'(oReady4), 32'd1);
    next_cycle();

    // 1: single beat, one-cycle latency then empty
    beat(2, 1'b1, 1'b1);
    @(negedge clk);
    chk("t1_valid", 32'(oValid4), 32'd1);
    next_cycle();
    @(negedge clk);
    chk("t1_drained", 32'(oValid4), 32'd0);
    next_cycle();

    // 2: streaming at full rate
    for (int s = 0; s < 4; s++) beat(s, 1'b1, 1'b1);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b1);

    // 3: stall fills skid, then drain in order
    beat(1, 1'b0, 1'b1);
    beat(3, 1'b0, 1'b1);
    idle(1'b0, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b1);

    // 4: out-of-range select on the N=3 instance, then a legal one
    beat(3, 1'b1, 1'b1);
    beat(0, 1'b1, 1'b1);
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b1);

    // 5: flush with both entries full drops everything, including the new beat
    beat(0, 1'b0, 1'b1);
    beat(1, 1'b0, 1'b1);
    iFlush = 1'b1; iValid = 1'b1; iSel = 2'd2; iReady = 1'b0;
    @(negedge clk);
    chk("t5_flush_oReady", 32'(oReady4), 32'd0);
    next_cycle();
    q4.delete(); q3.delete();
    iFlush = 1'b0; iValid = 1'b0;
    @(negedge clk);
    chk_empty_out("t5_post_flush", 1'b1);
    next_cycle();
    idle(1'b1, 1'b1);
    idle(1'b1, 1'b1);

    // 6: reset mid-stream with skid full
    beat(1, 1'b0, 1'b1);
    beat(3, 1'b0, 1'b1);
    rst = 1'b1; iValid = 1'b1; iSel = 2'd0; iReady = 1'b0;
    @(negedge clk);
    chk("t6_rst_oReady", 32'(oReady4), 32'd0);
    next_cycle();
    q4.delete(); q3.delete();
    @(negedge clk);
    chk_empty_out("t6_in_reset", 1'b0);
    next_cycle();
    rst = 1'b0; iValid = 1'b0; iReady = 1'b1;
    @(negedge clk);
    chk("t6_release_oReady", 32'(oReady4), 32'd1);
    next_cycle();
    beat(2, 1'b1, 1'b1);
    @(negedge clk);
    chk("t6_latency_valid", 32'(oValid4), 32'd1);
    next_cycle();
    idle(1'b1, 1'b1);

    chk("q4_drained", 32'(q4.size()), 32'd0);
    chk("q3_drained", 32'(q3.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
